instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
Sequential RV32I instruction encoder and program loader. Accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit instruction words. It checks the opcode and immediate range, then writes each legal word to instruction memory at consecutive word addresses. It sits between a test/boot sequencer and the instruction memory, and produces the words that the decode stage later splits back into fields.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written
MAX_WORDS, 256, capacity in words; the loader stops accepting at this count
AW, 32, width of wr_addr

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
clear  input  1  synchronous restart: address and count return to base, error cleared
in_valid  input  1  field tuple valid
in_ready  output  1  loader can accept a tuple this cycle
opcode  input  7  opcode field
rd  input  5  destination register
funct3  input  3  funct3 field
rs1  input  5  source register 1
rs2  input  5  source register 2
funct7  input  7  funct7 field (R-type only)
imm  input  32  signed byte-offset / immediate value (U-type: full value, low 12 bits zero)
wr_en  output  1  memory write request
wr_ready  input  1  memory accepts the write this cycle
wr_addr  output  AW  byte address = BASE_ADDR + 4*word_count
wr_data  output  32  encoded instruction
word_count  output  $clog2(MAX_WORDS+1)  words committed to memory
full  output  1  word_count + wr_en == MAX_WORDS
err  output  1  sticky, set on any rejected tuple
err_code  output  2  last rejection: 01 illegal opcode, 10 immediate out of range

Behaviour:
- Reset (rst_n low, asynchronous): wr_en=0, wr_data=0, wr_addr=BASE_ADDR, word_count=0, err=0, err_code=00, full=0. in_ready is 0 while rst_n is low.
- Handshake: a tuple is accepted when in_valid && in_ready. in_ready = !clear && !full && (!wr_en || wr_ready).
- Output register: an accepted legal tuple loads wr_data and sets wr_en on the next cycle (latency 1).
- wr_en, wr_data and wr_addr stay stable until wr_en && wr_ready.
- On a write handshake: word_count += 1 and wr_addr += 4. If a new tuple is accepted in the same cycle, wr_en stays 1 with the new data, so throughput is 1 word/cycle.
- Encoding, {msb..lsb}:
  - R (0110011): {funct7, rs2, rs1, funct3, rd, op}
  - I (0000011, 0010011, 1100111): {imm[11:0], rs1, funct3, rd, op}
  - S (0100011): {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - B (1100011): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
  - U (0110111, 0010111): {imm[31:12], rd, op}
  - J (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
- Range checks, with imm treated as two's complement:
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and imm[0]=0.
  - J: imm in [-2^20, 2^20-2] and imm[0]=0.
  - U: imm[11:0]=0.
  - Fields unused by a format are ignored.
- Rejection:
  - An opcode outside the list above, or a range violation, is still consumed (handshake completes).
  - No write is issued and word_count is unchanged.
  - err is set to 1 and err_code is updated. Illegal opcode takes priority over range.
- full: once asserted, in_ready=0. full deasserts only on clear or reset.
- clear:
  - Any pending write is dropped: wr_en=0 next cycle.
  - word_count=0, wr_addr=BASE_ADDR, err=0, err_code=00.
  - A tuple presented in the clear cycle is not accepted.
- Reset or clear mid-write: the dropped word is never counted. Memory sees wr_en fall without a handshake, which is legal.

Test Plan:
- Write ADD x3,x1,x2 (op 0110011, f3 0, f7 0) -> wr_data=0x002081B3 at wr_addr=BASE_ADDR on the following cycle; word_count=1 after wr_ready.
- Write SW x5,-4(x2), then BEQ x1,x2,+8, then JAL x1,+2048 back-to-back with wr_ready=1 -> wr_data 0xFE512E23, 0x00208463, 0x001000EF on consecutive cycles at BASE+0/+4/+8.
- Hold wr_ready=0 for 3 cycles with a word pending -> wr_en/wr_data/wr_addr stable, in_ready=0, word_count unchanged; release -> word commits and the next tuple is accepted the same cycle.
- Write opcode 0x7F, then ADDI imm=2048, then BEQ imm=6+1 (odd) -> no writes; err=1 with err_code 01, then 10, then 10; word_count unchanged; a subsequent valid ADD still writes at the unchanged address.
- With MAX_WORDS=4, stream 6 tuples -> exactly 4 writes, full=1, in_ready=0; assert clear -> word_count=0, wr_addr=BASE_ADDR, full=0, err=0.
- Assert rst_n low mid-backpressure with wr_en=1 -> all outputs return to reset values immediately; after release, the first write goes to BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// RV32I field-to-word encoder that streams legal words into instruction memory at consecutive addresses.
// Latency: 1 cycle from tuple acceptance to wr_en/wr_data; sustains 1 word/cycle when wr_ready stays high.
// Backpressure: in_ready drops while a write is stalled by wr_ready, during clear, and once the program is full.
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256,
    parameter int          AW        = 32,
    localparam int         CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [6:0]    opcode,
    input  logic [4:0]    rd,
    input  logic [2:0]    funct3,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [6:0]    funct7,
    input  logic [31:0]   imm,
    output logic          wr_en,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic [CW-1:0] word_count,
    output logic          full,
    output logic          err,
    output logic [1:0]    err_code
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_J    = 7'b1101111;

    localparam logic [1:0] CODE_OPCODE = 2'b01;
    localparam logic [1:0] CODE_RANGE  = 2'b10;

    logic signed [31:0] simm;
    logic [31:0]        enc;
    logic               op_ok;
    logic               range_ok;
    logic               accept;

    assign simm = $signed(imm);

    always_comb begin
        enc      = '0;
        op_ok    = 1'b1;
        range_ok = 1'b1;
        unique case (opcode)
            OP_R: enc = {funct7, rs2, rs1, funct3, rd, opcode};
            OP_LOAD, OP_IMM, OP_JALR: begin
                enc      = {imm[11:0], rs1, funct3, rd, opcode};
                range_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            OP_S: begin
                enc      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            OP_B: begin
                enc      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_ok = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
            end
            OP_LUI, OP_AUIPC: begin
                enc      = {imm[31:12], rd, opcode};
                range_ok = (imm[11:0] == 12'h000);
            end
            OP_J: begin
                enc      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                range_ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];
            end
            default: op_ok = 1'b0;
        endcase
    end

    // A word still held in the output register counts toward capacity, so full can never overshoot.
    assign full     = (({1'b0, word_count} + (CW+1)'(wr_en)) == (CW+1)'(MAX_WORDS));
    assign in_ready = rst_n && !clear && !full && (!wr_en || wr_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_data    <= '0;
            wr_addr    <= AW'(BASE_ADDR);
            word_count <= '0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else if (clear) begin
            wr_en      <= 1'b0;
            wr_addr    <= AW'(BASE_ADDR);
            word_count <= '0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            if (wr_en && wr_ready) begin
                wr_en      <= 1'b0;
                wr_addr    <= wr_addr + AW'(4);
                word_count <= word_count + CW'(1);
            end
            // A same-cycle accept overrides the wr_en drop above, keeping the pipe streaming.
            if (accept) begin
                if (op_ok && range_ok) begin
                    wr_en   <= 1'b1;
                    wr_data <= enc;
                end else begin
                    err      <= 1'b1;
                    err_code <= op_ok ? CODE_RANGE : CODE_OPCODE;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed bench for instr_encoder_loader against a transaction-level reference model.
module tb_instr_encoder_loader;

    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam int          MAXW = 4;
    localparam int          CW   = $clog2(MAXW + 1);

    logic          clk = 1'b0;
    logic          rst_n, clear, in_valid, in_ready;
    logic [6:0]    opcode, funct7;
    logic [4:0]    rd, rs1, rs2;
    logic [2:0]    funct3;
    logic [31:0]   imm;
    logic          wr_en, wr_ready;
    logic [31:0]   wr_addr, wr_data;
    logic [CW-1:0] word_count;
    logic          full, err;
    logic [1:0]    err_code;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
    } tup_t;

    // Reference state: one pending word, committed count, sticky error.
    bit          m_pend;
    logic [31:0] m_data;
    int          m_cnt;
    bit          m_err;
    logic [1:0]  m_code;

    logic [6:0] legal_ops [9] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    instr_encoder_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .AW(32)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
        .imm(imm), .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .word_count(word_count), .full(full), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic tup_t mk(logic [6:0] op, logic [4:0] rd_, logic [2:0] f3, logic [4:0] r1,
                                logic [4:0] r2, logic [6:0] f7, logic [31:0] im);
        tup_t t;
        t.op = op; t.rd = rd_; t.f3 = f3; t.rs1 = r1; t.rs2 = r2; t.f7 = f7; t.imm = im;
        return t;
    endfunction

    // Builds the word by shifting and masking fields into place, and judges legality by integer range.
    task automatic ref_enc(input tup_t t, output bit ok, output logic [1:0] code, output logic [31:0] w);
        int          v;
        logic [31:0] i, base_reg;
        v  = $signed(t.imm);
        i  = t.imm;
        ok = 1'b1;
        code = 2'b00;
        w  = 32'h0;
        base_reg = (32'(t.rs1) << 15) | (32'(t.f3) << 12) | 32'(t.op);
        case (t.op)
            7'h33: w = (32'(t.f7) << 25) | (32'(t.rs2) << 20) | base_reg | (32'(t.rd) << 7);
            7'h03, 7'h13, 7'h67: begin
                w  = ((i & 32'hFFF) << 20) | base_reg | (32'(t.rd) << 7);
                ok = (v >= -2048) && (v <= 2047);
            end
            7'h23: begin
                w  = (((i >> 5) & 32'h7F) << 25) | (32'(t.rs2) << 20) | base_reg | ((i & 32'h1F) << 7);
                ok = (v >= -2048) && (v <= 2047);
            end
            7'h63: begin
                w  = (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3F) << 25) | (32'(t.rs2) << 20) | base_reg
                   | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 1) << 7);
                ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
            end
            7'h37, 7'h17: begin
                w  = (i & 32'hFFFF_F000) | (32'(t.rd) << 7) | 32'(t.op);
                ok = ((i & 32'hFFF) == 0);
            end
            7'h6F: begin
                w  = (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3FF) << 21) | (((i >> 11) & 1) << 20)
                   | (((i >> 12) & 32'hFF) << 12) | (32'(t.rd) << 7) | 32'(t.op);
                ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
            end
            default: begin
                ok   = 1'b0;
                code = 2'b01;
            end
        endcase
        if (!ok && code == 2'b00) code = 2'b10;
    endtask

    function automatic bit m_full();
        return (m_cnt + int'(m_pend)) == MAXW;
    endfunction

    // One cycle: drive at negedge, check readiness, advance the model at posedge, check outputs at next negedge.
    task automatic step(input bit v, input tup_t t, input bit wrr, input bit clr);
        bit          exp_rdy, ok;
        logic [1:0]  code;
        logic [31:0] w;
        in_valid = v; opcode = t.op; rd = t.rd; funct3 = t.f3; rs1 = t.rs1; rs2 = t.rs2;
        funct7 = t.f7; imm = t.imm; wr_ready = wrr; clear = clr;
        #1;
        exp_rdy = !clr && !m_full() && (!m_pend || wrr);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (clr) begin
            m_pend = 0; m_cnt = 0; m_err = 0; m_code = 2'b00;
        end else begin
            if (m_pend && wrr) begin
                m_cnt++;
                m_pend = 0;
            end
            if (v && exp_rdy) begin
                ref_enc(t, ok, code, w);
                if (ok) begin
                    m_pend = 1; m_data = w;
                end else begin
                    m_err = 1; m_code = code;
                end
            end
        end
        @(negedge clk);
        check("wr_en", 32'(wr_en), 32'(m_pend));
        if (m_pend) check("wr_data", wr_data, m_data);
        check("wr_addr", wr_addr, BASE + 32'(4 * m_cnt));
        check("word_count", 32'(word_count), 32'(m_cnt));
        check("full", 32'(full), 32'(m_full()));
        check("err", 32'(err), 32'(m_err));
        check("err_code", 32'(err_code), 32'(m_code));
    endtask

    function automatic tup_t rand_tup();
        tup_t t;
        t.op  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
        t.rd  = 5'($urandom); t.f3 = 3'($urandom); t.rs1 = 5'($urandom);
        t.rs2 = 5'($urandom); t.f7 = 7'($urandom);
        case ($urandom_range(0, 3))
            0:       t.imm = $urandom;
            1:       t.imm = 32'($urandom_range(0, 10000)) - 32'd5000;
            2:       t.imm = 32'($urandom_range(0, 4194304)) - 32'd2097152;
            default: t.imm = $urandom & 32'hFFFF_F000;
        endcase
        return t;
    endfunction

    tup_t idle, add_t, addi_t;

    initial begin
        idle   = mk(7'h00, 0, 0, 0, 0, 0, 0);
        add_t  = mk(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
        addi_t = mk(7'h13, 5'd4, 3'd0, 5'd1, 5'd0, 7'd0, 32'd100);
        m_pend = 0; m_data = 0; m_cnt = 0; m_err = 0; m_code = 2'b00;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
        opcode = 0; rd = 0; funct3 = 0; rs1 = 0; rs2 = 0; funct7 = 0; imm = 0;

        repeat (2) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_wr_addr", wr_addr, BASE);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_err", {29'd0, err, err_code}, 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;

        // Single ADD, committed one cycle later.
        step(1, add_t, 0, 0);
        check("add_data", wr_data, 32'h0020_81B3);
        check("add_addr", wr_addr, BASE);
        step(0, idle, 1, 0);
        check("add_count", 32'(word_count), 32'd1);

        // SW / BEQ / JAL streamed back-to-back.
        step(0, idle, 1, 1);
        step(1, mk(7'h23, 0, 3'd2, 5'd2, 5'd5, 0, -32'sd4), 1, 0);
        check("sw_data", wr_data, 32'hFE51_2E23);
        check("sw_addr", wr_addr, BASE);
        step(1, mk(7'h63, 0, 3'd0, 5'd1, 5'd2, 0, 32'd8), 1, 0);
        check("beq_data", wr_data, 32'h0020_8463);
        check("beq_addr", wr_addr, BASE + 32'd4);
        step(1, mk(7'h6F, 5'd1, 0, 0, 0, 0, 32'd2048), 1, 0);
        check("jal_data", wr_data, 32'h0010_00EF);
        check("jal_addr", wr_addr, BASE + 32'd8);
        step(0, idle, 1, 0);
        check("stream_count", 32'(word_count), 32'd3);

        // Backpressure for 3 cycles, then release with a new tuple waiting.
        step(0, idle, 1, 1);
        step(1, add_t, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, addi_t, 0, 0);
            check("bp_data", wr_data, 32'h0020_81B3);
            check("bp_count", 32'(word_count), 32'd0);
        end
        step(1, addi_t, 1, 0);
        check("bp_release_count", 32'(word_count), 32'd1);
        check("bp_release_data", wr_data, 32'h0640_8213);

        // Rejections: illegal opcode, then two range violations.
        step(0, idle, 1, 1);
        step(1, mk(7'h7F, 1, 0, 1, 2, 0, 0), 1, 0);
        check("ill_code", 32'(err_code), 32'd1);
        step(1, mk(7'h13, 1, 0, 1, 0, 0, 32'd2048), 1, 0);
        check("addi_rng_code", 32'(err_code), 32'd2);
        step(1, mk(7'h63, 0, 0, 1, 2, 0, 32'd7), 1, 0);
        check("beq_odd_code", 32'(err_code), 32'd2);
        check("rej_count", 32'(word_count), 32'd0);
        check("rej_wr_en", 32'(wr_en), 32'd0);
        step(1, add_t, 1, 0);
        check("post_rej_addr", wr_addr, BASE);
        check("post_rej_err", 32'(err), 32'd1);

        // Capacity: six tuples offered, four written.
        step(0, idle, 1, 1);
        for (int k = 0; k < 6; k++) step(1, add_t, 1, 0);
        step(1, add_t, 1, 0);
        check("cap_count", 32'(word_count), 32'd4);
        check("cap_full", 32'(full), 32'd1);
        check("cap_in_ready", 32'(in_ready), 32'd0);
        step(0, idle, 1, 1);
        check("clr_count", 32'(word_count), 32'd0);
        check("clr_addr", wr_addr, BASE);
        check("clr_full", 32'(full), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++)
            step($urandom_range(0, 9) < 7, rand_tup(), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 39) == 0);

        // Asynchronous reset while a write is stalled.
        step(0, idle, 1, 1);
        step(1, add_t, 0, 0);
        step(0, idle, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wr_en", 32'(wr_en), 32'd0);
        check("arst_wr_addr", wr_addr, BASE);
        check("arst_wr_data", wr_data, 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        m_pend = 0; m_cnt = 0; m_err = 0; m_code = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, addi_t, 0, 0);
        check("arst_first_addr", wr_addr, BASE);
        step(0, idle, 1, 0);
        check("arst_first_count", 32'(word_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
